// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: one trial subtraction per clock,
// remainder to HI and quotient to LO after a sign fixup cycle.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dmag, dvd;
   logic             sign_q, sign_r, dz;
   logic             accept;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;

   // Negating the most-negative value wraps to itself, which is its correct
   // unsigned magnitude.
   assign a_mag   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign b_mag   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
   assign shifted = {rem, quo[WIDTH-1]};
   // One extra bit beyond the shifted remainder so the sign of the trial is
   // unambiguous even for full-range unsigned divisors.
   assign trial   = {1'b0, shifted} - {2'b0, dmag};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == '0) state_nx = FIX;
         end
         FIX: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         dmag        <= '0;
         dvd         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dz          <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt    <= CW'(WIDTH);
         rem    <= '0;
         quo    <= a_mag;
         dmag   <= b_mag;
         dvd    <= dividend;
         sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         sign_r <= is_signed & dividend[WIDTH-1];
         dz     <= (divisor == '0);
      end else if (state == RUN && cnt != '0) begin
         cnt <= cnt - 1'b1;
         if (!trial[WIDTH+1]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
         end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
         end
      end else if (state == FIX) begin
         div_by_zero <= dz;
         if (dz) begin
            quotient  <= '1;
            remainder <= dvd;
         end else begin
            quotient  <= sign_q ? -quo : quo;
            remainder <= sign_r ? -rem : rem;
         end
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_div_seq;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   div_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1, expected no pending result");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", W'(div_by_zero), W'(e.dz));
         end
      end
   end

   // Counts cycles after the accepting edge until done is seen.
   task automatic wait_done(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy) bcyc++;
         if (done) break;
         if (cyc > 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got no done in 100 cycles, expected done at 35");
            break;
         end
      end
   endtask

   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start     = 1'b1;
      is_signed = s;
      dividend  = a;
      divisor   = b;
   endtask

   task automatic run(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
      int c, bc;
      issue(s, a, b);
      sb.push_back('{q: q, r: r, dz: dz});
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(c, bc);
      check("latency", W'(c), W'(35));
      check("busy_cycles", W'(bc), W'(34));
   endtask

   initial begin
      int c, bc;
      #2;
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_quotient", quotient, '0);
      check("rst_remainder", remainder, '0);
      check("rst_dz", W'(div_by_zero), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
      run(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
      run(1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0);
      run(1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0);
      run(1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1);
      run(1'b0, 32'd10,         32'd3,          32'd3,          32'd1,          1'b0);
      run(1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1);
      run(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
      run(1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0);
      run(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0);

      // Start held high; operands changed mid-divide become the second divide.
      issue(1'b0, 32'd50, 32'd6);
      sb.push_back('{q: 32'd8, r: 32'd2, dz: 1'b0});
      @(posedge clk);
      repeat (5) @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd10;
      sb.push_back('{q: 32'd100, r: 32'd0, dz: 1'b0});
      wait_done(c, bc);
      check("held_latency", W'(c + 5), W'(35));
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(c, bc);
      check("b2b_latency", W'(c), W'(35));

      // Abort mid-run; results of the previous divide hold until then.
      issue(1'b0, 32'd77, 32'd7);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      check("run_busy", W'(busy), W'(1));
      check("hold_quotient", quotient, 32'd100);
      check("hold_remainder", remainder, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", W'(busy), '0);
      check("abort_quotient", quotient, '0);
      check("abort_remainder", remainder, '0);
      check("abort_dz", W'(div_by_zero), '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

      @(negedge clk);
      check("sb_empty", W'(sb.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1);
   end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle radix-2 restoring divider for the MIPS datapath, executing DIV/DIVU.
- Runs the inverse of the ALU add path: one trial subtraction per clock.
- Sits beside the ALU and drives the HI/LO write path (remainder to HI, quotient to LO).
- The control unit starts it and stalls on busy until done.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin divide; accepted only when busy=0
is_signed  input  1  1=DIV (two's complement), 0=DIVU; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high while a divide is in progress
done  output  1  one-cycle pulse when quotient/remainder are valid
quotient  output  WIDTH  result for LO
remainder  output  WIDTH  result for HI
div_by_zero  output  1  divisor was zero for the last completed divide; valid with and after done

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and working registers cleared.
- Reset mid-operation aborts the divide; no done pulse follows.
- States: IDLE, RUN, FIX, DONE.
- IDLE: busy=0. On start=1, capture operands and go to RUN.
  - For signed operation, capture |dividend| and |divisor| (magnitude of most-negative value = 2^(WIDTH-1), held unsigned).
  - Record sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - Record dz = (divisor==0).
  - Set counter=WIDTH.
- RUN: busy=1. Each cycle perform one restoring step:
  - Shift {rem, quo} left by 1.
  - Trial = rem_shifted - divisor_mag, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo LSB = 1; else quo LSB = 0.
  - Decrement counter; after WIDTH steps go to FIX.
- FIX: busy=1, one cycle.
  - Signed and not dz: quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem.
  - Unsigned: pass quo and rem through.
  - Load output registers; go to DONE.
- DONE: busy=0, done=1 for exactly this cycle.
  - Next state is IDLE, or RUN if start=1 (back-to-back accept).
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH+2, i.e. WIDTH+3 cycles total (35 for WIDTH=32).
- start while busy=1 is ignored; no queuing, and in-flight operands are unaffected.
- quotient, remainder and div_by_zero hold their values from DONE until the FIX of the next divide. They do not change when a new start is accepted.
- Divide by zero:
  - Same latency; div_by_zero=1.
  - quotient = all ones; remainder = original dividend bit pattern (signed fixup suppressed).
  - div_by_zero clears at FIX of the next divide with a nonzero divisor.
- Signed semantics: quotient truncates toward zero; remainder takes the sign of the dividend (or is 0).
- Signed overflow (dividend = 2^(WIDTH-1) pattern, divisor = -1): quotient = 0x80000000 (two's-complement wrap), remainder=0, no flag.
- Arithmetic is internal WIDTH+1 bits; no other exception outputs.

Test Plan:
1. Unsigned 100 / 7, start pulse one cycle -> busy high 34 cycles, done pulse in cycle 35; quotient=14, remainder=2, div_by_zero=0.
2. Signed -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
   Signed 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
   DIVU 0xFFFFFFF9 / 2 -> quotient=0x7FFFFFFC, remainder=1.
3. Divide by zero: DIVU 0x1234 / 0 -> quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1. A following 10 / 3 clears the flag: quotient=3, remainder=1.
4. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
   Signed 0x80000000 / 2 -> quotient=0xC0000000, remainder=0.
5. Start held high across a divide, with operands changed in cycle 5 -> only the first operands are used. Second divide accepted in the DONE cycle; its done arrives 35 cycles later, with no idle gap required.
6. rst_n pulled low in cycle 10 of RUN -> all outputs 0 immediately (async). No done pulse. A new start after release completes normally: 9 / 4 -> quotient=2, remainder=1.
